// File: rtl/saida_display_n_if.sv
// rtl/saida_display_n_if.sv - result capture and 7-segment output bus for saida_display_n
interface saida_display_n_if #(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 4
);
  logic                 escrever;
  logic [LARGURA-1:0]   entrada;
  logic                 modo;
  logic                 com_sinal;
  logic [DIGITOS*7-1:0] segmentos;
  logic                 ocupado;
  logic                 pronto;
  logic                 estouro;

  modport master (
    output escrever, entrada, modo, com_sinal,
    input  segmentos, ocupado, pronto, estouro
  );

  modport slave (
    input  escrever, entrada, modo, com_sinal,
    output segmentos, ocupado, pronto, estouro
  );
endinterface

// File: rtl/saida_display_n.sv
// rtl/saida_display_n.sv - parametrised hex/decimal 7-segment result display (optional SAIDA_DISPLAY_BLANK_EN blanks leading zeros)
module saida_display_n #(
  parameter int LARGURA = 32,
  parameter int DIGITOS = 4
) (
  input  logic         clock,
  input  logic         reseta,
  saida_display_n_if.slave bus
);

  localparam int NB = 4 * DIGITOS;
  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [6:0] SEG_MENOS   = 7'b0111111;
  localparam logic [6:0] SEG_APAGADO = 7'h7F;

  function automatic logic [63:0] pot10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest magnitude each rendering can show without overflow
  localparam logic [63:0] LIM_HEX = (64'd1 << NB) - 64'd1;
  localparam logic [63:0] LIM_DEC = pot10(DIGITOS) - 64'd1;
  localparam logic [63:0] LIM_NEG = pot10(DIGITOS - 1) - 64'd1;

  function automatic logic [6:0] glifo(input logic [3:0] v);
    case (v)
      4'h0: glifo = 7'b1000000;
      4'h1: glifo = 7'b1111001;
      4'h2: glifo = 7'b0100100;
      4'h3: glifo = 7'b0110000;
      4'h4: glifo = 7'b0011001;
      4'h5: glifo = 7'b0010010;
      4'h6: glifo = 7'b0000010;
      4'h7: glifo = 7'b1111000;
      4'h8: glifo = 7'b0000000;
      4'h9: glifo = 7'b0010000;
      4'hA: glifo = 7'b0001000;
      4'hB: glifo = 7'b0000011;
      4'hC: glifo = 7'b1000110;
      4'hD: glifo = 7'b0100001;
      4'hE: glifo = 7'b0000110;
      4'hF: glifo = 7'b0001110;
      default: glifo = SEG_APAGADO;
    endcase
  endfunction

  typedef enum logic [1:0] {OCIOSO, CAPTURA, CONVERTE, CARREGA} estado_t;

  estado_t              estado_q, estado_d;
  logic [LARGURA-1:0]   dado_q, dado_d;
  logic [LARGURA-1:0]   shift_q, shift_d;
  logic                 modo_q, modo_d;
  logic                 sinal_q, sinal_d;
  logic                 neg_q, neg_d;
  logic                 ovf_q, ovf_d;
  logic [NB-1:0]        bcd_q, bcd_d;
  logic [CW-1:0]        cont_q, cont_d;
  logic [7*DIGITOS-1:0] seg_q, seg_d;
  logic                 pronto_q, pronto_d;
  logic                 estouro_q, estouro_d;

  logic [LARGURA-1:0]   mag;
  logic                 neg_cap;
  logic                 carry;
  logic [3:0]           dig;
  logic [NB-1:0]        hex_nib;
  logic [NB-1:0]        nib;
  logic [7*DIGITOS-1:0] padrao;
`ifdef SAIDA_DISPLAY_BLANK_EN
  int                   msd;
`endif

  // Next-state logic of the capture/convert/load sequence
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:   if (bus.escrever) estado_d = CAPTURA;
      CAPTURA:  estado_d = modo_q ? CONVERTE : CARREGA;
      CONVERTE: if (cont_q == CW'(1)) estado_d = CARREGA;
      CARREGA:  estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reseta) begin
    if (!reseta) estado_q <= OCIOSO;
    else         estado_q <= estado_d;
  end

  // Sign and magnitude of the latched value; negation covers the most-negative input
  always_comb begin
    neg_cap = sinal_q & modo_q & dado_q[LARGURA-1];
    mag     = neg_cap ? (-dado_q) : dado_q;
  end

  // Capture, overflow decision and one double-dabble step per CONVERTE cycle
  always_comb begin
    dado_d  = dado_q;
    modo_d  = modo_q;
    sinal_d = sinal_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cont_d  = cont_q;
    carry   = 1'b0;
    dig     = 4'd0;
    case (estado_q)
      OCIOSO: begin
        if (bus.escrever) begin
          dado_d  = bus.entrada;
          modo_d  = bus.modo;
          sinal_d = bus.com_sinal;
        end
      end
      CAPTURA: begin
        neg_d   = neg_cap;
        shift_d = mag;
        bcd_d   = '0;
        cont_d  = CW'(LARGURA);
        if (!modo_q)      ovf_d = 64'(mag) > LIM_HEX;
        else if (neg_cap) ovf_d = 64'(mag) > LIM_NEG;
        else              ovf_d = 64'(mag) > LIM_DEC;
      end
      CONVERTE: begin
        // Carry out of the top nibble is dropped: overflow is already known
        carry = shift_q[LARGURA-1];
        for (int k = 0; k < DIGITOS; k++) begin
          dig = bcd_q[4*k +: 4];
          if (dig >= 4'd5) dig = dig + 4'd3;
          bcd_d[4*k +: 4] = {dig[2:0], carry};
          carry = dig[3];
        end
        shift_d = {shift_q[LARGURA-2:0], 1'b0};
        cont_d  = cont_q - CW'(1);
      end
      default: ;
    endcase
  end

  generate
    if (NB > LARGURA) begin : g_hex_ext
      assign hex_nib = {{(NB-LARGURA){1'b0}}, shift_q};
    end else if (NB == LARGURA) begin : g_hex_eq
      assign hex_nib = shift_q;
    end else begin : g_hex_trunc
      assign hex_nib = shift_q[NB-1:0];
    end
  endgenerate

  // Glyph pattern for the converted digits, with sign and overflow substitution
  always_comb begin
    nib    = modo_q ? bcd_q : hex_nib;
    padrao = '0;
`ifdef SAIDA_DISPLAY_BLANK_EN
    msd = 0;
    for (int k = 0; k < DIGITOS; k++) begin
      if (nib[4*k +: 4] != 4'd0) msd = k;
    end
`endif
    for (int k = 0; k < DIGITOS; k++) begin
      padrao[7*k +: 7] = glifo(nib[4*k +: 4]);
`ifdef SAIDA_DISPLAY_BLANK_EN
      if (k > msd) padrao[7*k +: 7] = SEG_APAGADO;
      if (neg_q && (k == msd + 1)) padrao[7*k +: 7] = SEG_MENOS;
`else
      if (neg_q && (k == DIGITOS - 1)) padrao[7*k +: 7] = SEG_MENOS;
`endif
    end
    if (ovf_q) padrao = {DIGITOS{SEG_MENOS}};
  end

  // Output registers change only in CARREGA, so a partial result never shows
  always_comb begin
    seg_d     = seg_q;
    pronto_d  = 1'b0;
    estouro_d = estouro_q;
    if (estado_q == CARREGA) begin
      seg_d     = padrao;
      pronto_d  = 1'b1;
      estouro_d = ovf_q;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or negedge reseta) begin
    if (!reseta) begin
      dado_q    <= '0;
      modo_q    <= 1'b0;
      sinal_q   <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      shift_q   <= '0;
      bcd_q     <= '0;
      cont_q    <= '0;
      seg_q     <= {DIGITOS{SEG_APAGADO}};
      pronto_q  <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      dado_q    <= dado_d;
      modo_q    <= modo_d;
      sinal_q   <= sinal_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cont_q    <= cont_d;
      seg_q     <= seg_d;
      pronto_q  <= pronto_d;
      estouro_q <= estouro_d;
    end
  end

  assign bus.segmentos = seg_q;
  assign bus.pronto    = pronto_q;
  assign bus.estouro   = estouro_q;
  assign bus.ocupado   = (estado_q != OCIOSO);

endmodule

// File: tb/tb_saida_display_n.sv
// tb/tb_saida_display_n.sv - scoreboard bench for saida_display_n
module tb_saida_display_n;
  localparam int LARGURA = 32;
  localparam int DIGITOS = 4;

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
    int          ciclo;
  } esp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   erros = 0;
  int   ciclo = 0;
  int   n_pronto = 0;
  esp_t fila[$];

  saida_display_n_if #(.LARGURA(LARGURA), .DIGITOS(DIGITOS)) bus();

  saida_display_n #(.LARGURA(LARGURA), .DIGITOS(DIGITOS)) dut (
    .clock  (clk),
    .reseta (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  function automatic logic [6:0] glifo(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic esp_t modelo(input logic [31:0] v, input logic m, input logic s);
    esp_t e;
    logic [63:0] mag;
    logic [63:0] base;
    logic [63:0] lim;
    logic neg;
    int d;
    int msd;
    neg  = m & s & v[31];
    mag  = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
    base = m ? 64'd10 : 64'd16;
    lim  = !m ? 64'd65535 : (neg ? 64'd999 : 64'd9999);
    e.ovf = (mag > lim);
    e.seg = '0;
    e.ciclo = 0;
    msd = 0;
    for (int k = 0; k < 4; k++) begin
      d = int'(mag % base);
      mag = mag / base;
      if (d != 0) msd = k;
      e.seg[7*k +: 7] = glifo(d);
    end
`ifdef SAIDA_DISPLAY_BLANK_EN
    for (int k = 0; k < 4; k++) begin
      if (k > msd) e.seg[7*k +: 7] = 7'h7F;
      if (neg && k == msd + 1) e.seg[7*k +: 7] = 7'h3F;
    end
`else
    if (neg) e.seg[27:21] = 7'h3F;
`endif
    if (e.ovf) e.seg = {4{7'h3F}};
    return e;
  endfunction

  // One cycle forward; every pronto pulse is matched against the scoreboard
  task automatic passo();
    esp_t e;
    @(negedge clk);
    #1;
    if (bus.pronto === 1'b1) begin
      n_pronto++;
      if (fila.size() == 0) begin
        checks++; erros++;
        $display("FAIL pronto_inesperado ciclo=%0d seg=%h exigido=nenhum", ciclo, bus.segmentos);
      end else begin
        e = fila.pop_front();
        checks++;
        if (bus.segmentos !== e.seg) begin
          erros++;
          $display("FAIL segmentos obtido=%h exigido=%h", bus.segmentos, e.seg);
        end
        checks++;
        if (bus.estouro !== e.ovf) begin
          erros++;
          $display("FAIL estouro obtido=%b exigido=%b", bus.estouro, e.ovf);
        end
        checks++;
        if (ciclo !== e.ciclo) begin
          erros++;
          $display("FAIL latencia ciclo obtido=%0d exigido=%0d", ciclo, e.ciclo);
        end
      end
    end
  endtask

  task automatic pulso(input logic [31:0] v, input logic m, input logic s);
    esp_t e;
    passo();
    bus.entrada = v; bus.modo = m; bus.com_sinal = s; bus.escrever = 1'b1;
    passo();
    bus.escrever = 1'b0;
    bus.entrada = $urandom; bus.modo = ~m; bus.com_sinal = ~s;
    e = modelo(v, m, s);
    e.ciclo = ciclo + (m ? LARGURA + 2 : 2);
    fila.push_back(e);
  endtask

  task automatic wait_vazio(input int budget);
    for (int i = 0; i < budget && fila.size() != 0; i++) passo();
    checks++;
    if (fila.size() != 0) begin
      erros++;
      $display("FAIL timeout_fila pendentes=%0d exigido=0", fila.size());
      fila.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) passo();
    checks++;
    if (bus.segmentos !== 28'hFFFFFFF || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 || bus.estouro !== 1'b0) begin
      erros++;
      $display("FAIL reset_inicial seg=%h ocu=%b pro=%b est=%b exigido=fffffff/0/0/0",
               bus.segmentos, bus.ocupado, bus.pronto, bus.estouro);
    end
    rst_n = 1'b1;
    passo();
  endtask

  task automatic test_hex();
    pulso(32'h0000_BEEF, 1'b0, 1'b0);
    wait_vazio(10);
    checks++;
    if (bus.segmentos !== {7'h03, 7'h06, 7'h06, 7'h0E}) begin
      erros++;
      $display("FAIL hex_beef obtido=%h exigido=%h", bus.segmentos, {7'h03, 7'h06, 7'h06, 7'h0E});
    end
    passo();
    checks++;
    if (bus.pronto !== 1'b0) begin
      erros++;
      $display("FAIL pronto_largura obtido=%b exigido=0", bus.pronto);
    end
    pulso(32'h0001_0000, 1'b0, 1'b0);
    wait_vazio(10);
    pulso(32'h0000_FFFF, 1'b0, 1'b1);
    wait_vazio(10);
    pulso(32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_vazio(10);
  endtask

  task automatic test_dec_unsigned();
    pulso(32'd1234, 1'b1, 1'b0);
    wait_vazio(60);
    checks++;
    if (bus.segmentos !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
      erros++;
      $display("FAIL dec_1234 obtido=%h exigido=%h", bus.segmentos, {7'h79, 7'h24, 7'h30, 7'h19});
    end
    pulso(32'd9999, 1'b1, 1'b0);
    wait_vazio(60);
    pulso(32'd10000, 1'b1, 1'b0);
    wait_vazio(60);
    pulso(32'd0, 1'b1, 1'b0);
    wait_vazio(60);
  endtask

  task automatic test_dec_signed();
    pulso(32'hFFFF_FF85, 1'b1, 1'b1);
    wait_vazio(60);
    checks++;
    if (bus.segmentos !== {7'h3F, 7'h79, 7'h24, 7'h30}) begin
      erros++;
      $display("FAIL dec_menos123 obtido=%h exigido=%h", bus.segmentos, {7'h3F, 7'h79, 7'h24, 7'h30});
    end
    pulso(-32'sd999, 1'b1, 1'b1);
    wait_vazio(60);
    pulso(32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_vazio(60);
    pulso(-32'sd1000, 1'b1, 1'b1);
    wait_vazio(60);
    pulso(32'h8000_0000, 1'b1, 1'b1);
    wait_vazio(60);
  endtask

  task automatic test_reset_abort();
    int base;
    passo();
    bus.entrada = 32'd1234; bus.modo = 1'b1; bus.com_sinal = 1'b0; bus.escrever = 1'b1;
    passo();
    bus.escrever = 1'b0;
    repeat (9) passo();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.segmentos !== 28'hFFFFFFF || bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 || bus.estouro !== 1'b0) begin
      erros++;
      $display("FAIL reset_abort seg=%h ocu=%b pro=%b est=%b exigido=fffffff/0/0/0",
               bus.segmentos, bus.ocupado, bus.pronto, bus.estouro);
    end
    base = n_pronto;
    repeat (3) passo();
    rst_n = 1'b1;
    repeat (40) passo();
    checks++;
    if (n_pronto !== base || bus.ocupado !== 1'b0 || bus.segmentos !== 28'hFFFFFFF) begin
      erros++;
      $display("FAIL pos_reset prontos=%0d ocu=%b seg=%h exigido=%0d/0/fffffff",
               n_pronto - base, bus.ocupado, bus.segmentos, 0);
    end
    pulso(32'h0000_0005, 1'b0, 1'b0);
    wait_vazio(10);
  endtask

  task automatic test_busy_drop();
    int base;
    base = n_pronto;
    pulso(32'd1234, 1'b1, 1'b0);
    repeat (4) passo();
    bus.entrada = 32'd42; bus.modo = 1'b1; bus.com_sinal = 1'b0; bus.escrever = 1'b1;
    passo();
    bus.escrever = 1'b0;
    wait_vazio(60);
    repeat (40) passo();
    checks++;
    if (n_pronto - base !== 1) begin
      erros++;
      $display("FAIL busy_drop prontos=%0d exigido=1", n_pronto - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    int t0;
    esp_t e;
    base = n_pronto;
    passo();
    bus.entrada = 32'd77; bus.modo = 1'b1; bus.com_sinal = 1'b0; bus.escrever = 1'b1;
    passo();
    t0 = ciclo;
    e = modelo(32'd77, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      e.ciclo = t0 + LARGURA + 2 + i * (LARGURA + 3);
      fila.push_back(e);
    end
    while (ciclo < t0 + LARGURA + 2 + 2 * (LARGURA + 3)) passo();
    bus.escrever = 1'b0;
    wait_vazio(10);
    repeat (40) passo();
    checks++;
    if (n_pronto - base !== 3) begin
      erros++;
      $display("FAIL back_to_back prontos=%0d exigido=3", n_pronto - base);
    end
  endtask

`ifdef SAIDA_DISPLAY_BLANK_EN
  task automatic test_blank();
    pulso(32'd7, 1'b1, 1'b0);
    wait_vazio(60);
    checks++;
    if (bus.segmentos !== {7'h7F, 7'h7F, 7'h7F, 7'h78}) begin
      erros++;
      $display("FAIL blank_7 obtido=%h exigido=%h", bus.segmentos, {7'h7F, 7'h7F, 7'h7F, 7'h78});
    end
    pulso(32'hFFFF_FFFB, 1'b1, 1'b1);
    wait_vazio(60);
    checks++;
    if (bus.segmentos !== {7'h7F, 7'h7F, 7'h3F, 7'h12}) begin
      erros++;
      $display("FAIL blank_menos5 obtido=%h exigido=%h", bus.segmentos, {7'h7F, 7'h7F, 7'h3F, 7'h12});
    end
    pulso(32'd0, 1'b1, 1'b0);
    wait_vazio(60);
    checks++;
    if (bus.segmentos !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      erros++;
      $display("FAIL blank_0 obtido=%h exigido=%h", bus.segmentos, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    pulso(32'h0000_00A0, 1'b0, 1'b0);
    wait_vazio(10);
  endtask
`endif

  initial begin
    bus.escrever = 1'b0;
    bus.entrada = '0;
    bus.modo = 1'b0;
    bus.com_sinal = 1'b0;
    test_reset();
    test_hex();
    test_dec_unsigned();
    test_dec_signed();
    test_reset_abort();
    test_busy_drop();
    test_back_to_back();
`ifdef SAIDA_DISPLAY_BLANK_EN
    test_blank();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
